// File: rtl/aes_pkg.sv
// Shared types, constants and index tables for the byte-serial ShiftRows stages.
package aes_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef byte_t [0:15]      state_t;

    // Pointer value of the 16th byte of a block.
    localparam logic [3:0] LAST_PTR = 4'd15;

    // Output position -> buffered input position, inverse row rotation.
    localparam logic [3:0] INV_IDX [16] = '{
        4'd0,  4'd13, 4'd10, 4'd7,
        4'd4,  4'd1,  4'd14, 4'd11,
        4'd8,  4'd5,  4'd2,  4'd15,
        4'd12, 4'd9,  4'd6,  4'd3
    };

    // Output position -> buffered input position, forward row rotation.
    localparam logic [3:0] FWD_IDX [16] = '{
        4'd0,  4'd5,  4'd10, 4'd15,
        4'd4,  4'd9,  4'd14, 4'd3,
        4'd8,  4'd13, 4'd2,  4'd7,
        4'd12, 4'd1,  4'd6,  4'd11
    };

    // Life cycle of one 16-entry bank.
    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

endpackage

// File: rtl/shift_row_bank.sv
// One 16-entry state buffer: sequential write port, permuted combinational
// read port, and a small FSM tracking whether the bank holds a whole block.
module shift_row_bank #(
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic [3:0]        wr_ptr_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic              fwd_i,
    input  logic              rd_en_i,
    input  logic [3:0]        rd_ptr_i,
    output logic [BYTE_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              busy_o
);
    import aes_pkg::*;

    bank_state_e       state_q, state_d;
    logic              fwd_q, fwd_d;
    logic [BYTE_W-1:0] mem_q [16];
    logic [3:0]        rd_idx;

    // Bank state and the rotation direction latched for the block it holds.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= BANK_EMPTY;
            fwd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fwd_q   <= fwd_d;
        end
    end

    // Next-state: first write opens the block, 16th write closes it,
    // first read starts the drain, 16th read frees the bank.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d = state_q;
        fwd_d   = fwd_q;
        if (clear_i) begin
            state_d = BANK_EMPTY;
        end else begin
            case (state_q)
                BANK_EMPTY: begin
                    if (wr_en_i) begin
                        state_d = BANK_FILLING;
                        fwd_d   = fwd_i;
                    end
                end
                BANK_FILLING: begin
                    if (wr_en_i && (wr_ptr_i == LAST_PTR)) state_d = BANK_FULL;
                end
                BANK_FULL: begin
                    if (rd_en_i) state_d = BANK_DRAINING;
                end
                BANK_DRAINING: begin
                    if (rd_en_i && (rd_ptr_i == LAST_PTR)) state_d = BANK_EMPTY;
                end
                default: state_d = BANK_EMPTY;
            endcase
        end
    end

    // Storage array; contents are only meaningful once the FSM says full.
    always_ff @(posedge clk) begin
        // NOTE: data array has no reset; validity is tracked by the FSM alone.
        if (wr_en_i) mem_q[wr_ptr_i] <= wr_data_i;
    end

    assign rd_idx    = fwd_q ? FWD_IDX[rd_ptr_i] : INV_IDX[rd_ptr_i];
    assign rd_data_o = mem_q[rd_idx];
    assign full_o    = (state_q == BANK_FULL) || (state_q == BANK_DRAINING);
    assign busy_o    = (state_q != BANK_EMPTY);

endmodule

// File: rtl/inv_shift_row_stream.sv
// Byte-serial AES InvShiftRows stage. Blocks of 16 column-major bytes are
// written into ping-pong banks and read back with the row rotation undone.
// Build option SHIFT_ROW_FWD_EN adds a per-block fwd input selecting the
// forward ShiftRows order instead.
module inv_shift_row_stream #(
    parameter int BYTE_W    = 8,
    parameter int NUM_BANKS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
`ifdef SHIFT_ROW_FWD_EN
    input  logic              fwd,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);
    import aes_pkg::*;

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [3:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BANK_W-1:0] wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [NUM_BANKS-1:0] full_w, busy_w;
    logic [BYTE_W-1:0] rd_data_w [NUM_BANKS];
    logic              wr_fire, rd_fire, fwd_w;

    // Round-robin successor of a bank select.
    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        next_bank = (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
    endfunction

`ifdef SHIFT_ROW_FWD_EN
    assign fwd_w = fwd;
`else
    assign fwd_w = 1'b0;
`endif

    // Handshakes; clear blanks both sides for the cycle it is asserted.
    assign in_ready  = !full_w[wr_bank_q] && !clear;
    assign wr_fire   = in_valid && in_ready;
    assign out_valid = full_w[rd_bank_q] && !clear;
    assign rd_fire   = out_valid && out_ready;
    assign out_data  = out_valid ? rd_data_w[rd_bank_q] : '0;
    assign out_last  = out_valid && (rd_ptr_q == LAST_PTR);
    assign busy      = |busy_w;

    // Pointer and bank-select update; clear overrides any handshake.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        rd_ptr_d  = rd_ptr_q;
        rd_bank_d = rd_bank_q;
        if (clear) begin
            wr_ptr_d  = '0;
            wr_bank_d = '0;
            rd_ptr_d  = '0;
            rd_bank_d = '0;
        end else begin
            if (wr_fire) begin
                if (wr_ptr_q == LAST_PTR) begin
                    wr_ptr_d  = '0;
                    wr_bank_d = next_bank(wr_bank_q);
                end else begin
                    wr_ptr_d = wr_ptr_q + 4'd1;
                end
            end
            if (rd_fire) begin
                if (rd_ptr_q == LAST_PTR) begin
                    rd_ptr_d  = '0;
                    rd_bank_d = next_bank(rd_bank_q);
                end else begin
                    rd_ptr_d = rd_ptr_q + 4'd1;
                end
            end
        end
    end

    // Pointer and bank-select registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            wr_bank_q <= '0;
            rd_ptr_q  <= '0;
            rd_bank_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            wr_bank_q <= wr_bank_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        shift_row_bank #(
            .BYTE_W (BYTE_W)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .clear_i   (clear),
            .wr_en_i   (wr_fire && (wr_bank_q == BANK_W'(b))),
            .wr_ptr_i  (wr_ptr_q),
            .wr_data_i (in_data),
            .fwd_i     (fwd_w),
            .rd_en_i   (rd_fire && (rd_bank_q == BANK_W'(b))),
            .rd_ptr_i  (rd_ptr_q),
            .rd_data_o (rd_data_w[b]),
            .full_o    (full_w[b]),
            .busy_o    (busy_w[b])
        );
    end

endmodule
